ball_motion_ctrl: RTL and testbench
===================================

// Module: ball_motion_ctrl
// PURPOSE
//  Per-frame position sequencer for up to CNT balls feeding the ball renderer (xs/ys/active bus).
//  On each frame_tick, walks the balls one per cycle: applies velocity, wall and paddle bounces, floor loss.
//  Results go to a shadow buffer and commit atomically at end of sweep, so the renderer never sees a half-updated frame.
//  Also serves launch requests from game control and reports ball loss.
// PARAMETERS
//  CNT       3    number of ball slots
//  SCR_W     640  playfield width, pixels
//  SCR_H     480  playfield height, pixels
//  RADIUS    4    ball radius, pixels (same value the renderer is given)
//  PADDLE_Y  440  top edge row of paddle
//  PADDLE_HW 32   paddle half-width, pixels
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous, active-high reset
//  frame_tick in   1       1-cycle pulse, start of vertical blank
//  launch     in   1       1-cycle pulse, request to serve a ball
//  paddle_x   in   10      paddle centre column
//  xs         out  CNT*10  committed ball x centres, slot i at [i*10+:10]
//  ys         out  CNT*10  committed ball y centres, slot i at [i*10+:10]
//  active     out  CNT     committed slot-valid mask
//  busy       out  1       high while sweep in progress
//  lost       out  1       1-cycle pulse, commit cycle, if >=1 ball fell past floor this sweep
//  overrun    out  1       1-cycle pulse, frame_tick arrived while busy
// BEHAVIOUR
//  Reset: xs=ys=0, active=0, busy=0, lost=0, overrun=0, all velocities 0, launch_pend=0, FSM=IDLE.
//  FSM: IDLE -> SWEEP (idx 0..CNT-1, one slot/cycle) -> COMMIT -> IDLE. Latency tick->committed = CNT+2 cycles.
//  IDLE: frame_tick -> idx=0, shadow<=committed, busy=1, go SWEEP.
//  SWEEP, slot idx inactive: copied unchanged. Active slot, 11-bit signed math, vx/vy 4-bit signed:
//   nx=x+vx; if nx<RADIUS: nx=RADIUS, vx=-vx; if nx>SCR_W-1-RADIUS: nx=SCR_W-1-RADIUS, vx=-vx.
//   ny=y+vy; if ny<RADIUS: ny=RADIUS, vy=-vy.
//   paddle: vy>0, ny+RADIUS>=PADDLE_Y, y+RADIUS<PADDLE_Y, |nx-paddle_x|<=PADDLE_HW -> ny=PADDLE_Y-RADIUS, vy=-vy.
//   floor: ny>SCR_H-1-RADIUS -> slot cleared (active=0, v=0), lost_flag set. Paddle check wins over floor.
//  COMMIT: shadow -> xs/ys/active in one cycle; lost pulses if lost_flag; busy drops next cycle.
//  launch: latched into launch_pend in any state; served in IDLE if no frame_tick that cycle
//   (frame_tick has priority, pend retained). Lowest-index inactive slot gets x=paddle_x clamped
//   to [RADIUS,SCR_W-1-RADIUS], y=PADDLE_Y-RADIUS-1, vx=+2, vy=-2; written straight to committed
//   regs; pend cleared. All slots active: pend cleared, request dropped.
//  frame_tick while busy: ignored, overrun pulses same cycle + 1.
//  rst mid-sweep: shadow discarded, all outputs to reset values next cycle.
//  Velocity regs are internal, never exposed; only COMMIT and launch modify committed outputs.
// STRUCTURE
//  Shared package/include: SCR_W, SCR_H, RADIUS, PADDLE_Y, PADDLE_HW, FSM state encodings,
//   launch velocity constants (shared with renderer and brick logic).
//  One sub-module: ball_step (combinational: x,y,vx,vy,paddle_x -> nx,ny,nvx,nvy,fell), instantiated once,
//   muxed by idx. Top holds FSM, shadow/committed buffers, launch logic.
// TESTING
//  1 rst, launch, paddle_x=320 -> next IDLE cycle slot0 active, xs[9:0]=320, ys[9:0]=435, busy=0.
//  2 slot0 at (100,200) v=(+2,-2), frame_tick -> after CNT+2 cycles xs=102, ys=198; busy high exactly CNT+1 cycles.
//  3 slot0 at (637,100) vx=+2 -> x=635, vx=-2; next frame x=633. Same check at left wall, x=5 vx=-2 -> 4 -> 6.
//  4 slot0 at (320,434) vy=+2, paddle_x=340 -> y=436, vy=-2; paddle_x=100 -> passes; at y=475 -> active=0, lost pulses once.
//  5 frame_tick again 2 cycles after first -> overrun 1 cycle, outputs match single-tick result; launch during sweep served after COMMIT.
//  6 rst asserted mid-sweep (idx=1) -> next cycle active=0, xs=ys=0, busy=0; launch with all 3 slots active -> no change.

Source files
------------

// File: rtl/ball_motion_ctrl_pkg.sv
// Shared definitions for the ball motion sequencer, the renderer and the brick logic.
//  - playfield geometry (screen size, ball radius, paddle placement)
//  - sequencer FSM state encoding
//  - serve velocity constants
//  - coordinate/velocity types and a clamp helper for serve placement
package ball_motion_ctrl_pkg;

  localparam int SCR_W     = 640;
  localparam int SCR_H     = 480;
  localparam int RADIUS    = 4;
  localparam int PADDLE_Y  = 440;
  localparam int PADDLE_HW = 32;

  typedef logic        [9:0]  coord_t;  // screen coordinate, unsigned pixels
  typedef logic signed [3:0]  vel_t;    // per-frame velocity, pixels/frame
  typedef logic signed [10:0] pos_t;    // signed working position during a step

  localparam vel_t LAUNCH_VX = 4'sd2;
  localparam vel_t LAUNCH_VY = -4'sd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Clamp a coordinate into [lo, hi].
  function automatic coord_t clamp_coord(input coord_t v, input int lo, input int hi);
    if (int'(v) < lo) return coord_t'(lo);
    if (int'(v) > hi) return coord_t'(hi);
    return v;
  endfunction

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// Bus between game control / renderer and the ball motion sequencer.
//  master: drives frame_tick, launch, paddle_x; observes the committed ball state.
//  slave : the sequencer itself.
//  xs/ys hold slot i at [i*10 +: 10]; active is the committed slot-valid mask.
interface ball_motion_ctrl_if #(
  parameter int CNT = 3
);
  logic              frame_tick;
  logic              launch;
  logic [9:0]        paddle_x;
  logic [CNT*10-1:0] xs;
  logic [CNT*10-1:0] ys;
  logic [CNT-1:0]    active;
  logic              busy;
  logic              lost;
  logic              overrun;

  modport master (
    output frame_tick, launch, paddle_x,
    input  xs, ys, active, busy, lost, overrun
  );

  modport slave (
    input  frame_tick, launch, paddle_x,
    output xs, ys, active, busy, lost, overrun
  );
endinterface

// File: rtl/ball_motion_ctrl_ball_step.sv
// ball_step: one frame of motion for a single ball (purely combinational).
//  in : x, y (centre), vx, vy (signed), paddle_x (paddle centre column)
//  out: nx, ny (new centre), nvx, nvy (new velocity), fell (ball dropped past the floor)
// Order: move, side walls, ceiling, paddle, floor. A paddle hit takes precedence over the floor.
module ball_step
  import ball_motion_ctrl_pkg::*;
#(
  parameter int SCR_W     = ball_motion_ctrl_pkg::SCR_W,
  parameter int SCR_H     = ball_motion_ctrl_pkg::SCR_H,
  parameter int RADIUS    = ball_motion_ctrl_pkg::RADIUS,
  parameter int PADDLE_Y  = ball_motion_ctrl_pkg::PADDLE_Y,
  parameter int PADDLE_HW = ball_motion_ctrl_pkg::PADDLE_HW
) (
  input  coord_t x,
  input  coord_t y,
  input  vel_t   vx,
  input  vel_t   vy,
  input  coord_t paddle_x,
  output coord_t nx,
  output coord_t ny,
  output vel_t   nvx,
  output vel_t   nvy,
  output logic   fell
);

  localparam pos_t MIN_C   = pos_t'(RADIUS);
  localparam pos_t MAX_X   = pos_t'(SCR_W - 1 - RADIUS);
  localparam pos_t FLOOR_Y = pos_t'(SCR_H - 1 - RADIUS);
  localparam pos_t PAD_TOP = pos_t'(PADDLE_Y);
  localparam pos_t PAD_REST = pos_t'(PADDLE_Y - RADIUS);
  localparam pos_t RAD     = pos_t'(RADIUS);
  localparam logic signed [11:0] HW = 12'(PADDLE_HW);

  pos_t               px, py;
  logic signed [11:0] dx, adx;
  logic               hit;

  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
  always_comb begin
    nvx = vx;
    nvy = vy;
    hit = 1'b0;

    px = $signed({1'b0, x}) + pos_t'(vx);
    if (px < MIN_C) begin
      px  = MIN_C;
      nvx = -vx;
    end else if (px > MAX_X) begin
      px  = MAX_X;
      nvx = -vx;
    end

    py = $signed({1'b0, y}) + pos_t'(vy);
    if (py < MIN_C) begin
      py  = MIN_C;
      nvy = -vy;
    end

    // Paddle only catches a descending ball on the frame its bottom edge crosses the paddle top.
    dx  = $signed({px[10], px}) - $signed({2'b00, paddle_x});
    adx = (dx < 12'sd0) ? -dx : dx;
    if ((vy > 4'sd0) && (py + RAD >= PAD_TOP) &&
        ($signed({1'b0, y}) + RAD < PAD_TOP) && (adx <= HW)) begin
      hit = 1'b1;
      py  = PAD_REST;
      nvy = -vy;
    end

    fell = !hit && (py > FLOOR_Y);

    nx = px[9:0];
    ny = py[9:0];
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-frame position sequencer for CNT balls.
//  clk, rst    : system clock, synchronous active-high reset
//  bus (slave) : frame_tick/launch/paddle_x in; xs/ys/active committed ball state,
//                busy (sweep in progress), lost (ball fell this sweep, commit pulse),
//                overrun (frame_tick arrived while busy) out.
// On frame_tick the committed state is copied to a shadow buffer, each slot is stepped
// one per cycle, and the shadow is committed in a single cycle so the renderer only ever
// sees whole frames. Serve requests are latched and placed directly into committed state
// while idle.
module ball_motion_ctrl
  import ball_motion_ctrl_pkg::*;
#(
  parameter int CNT       = 3,
  parameter int SCR_W     = ball_motion_ctrl_pkg::SCR_W,
  parameter int SCR_H     = ball_motion_ctrl_pkg::SCR_H,
  parameter int RADIUS    = ball_motion_ctrl_pkg::RADIUS,
  parameter int PADDLE_Y  = ball_motion_ctrl_pkg::PADDLE_Y,
  parameter int PADDLE_HW = ball_motion_ctrl_pkg::PADDLE_HW
) (
  input logic               clk,
  input logic               rst,
  ball_motion_ctrl_if.slave bus
);

  localparam int     IW      = (CNT > 1) ? $clog2(CNT) : 1;
  localparam coord_t SERVE_Y = coord_t'(PADDLE_Y - RADIUS - 1);

  // Committed state (visible to the renderer) and internal velocities.
  coord_t         xs_q [CNT];
  coord_t         ys_q [CNT];
  vel_t           vx_q [CNT];
  vel_t           vy_q [CNT];
  logic [CNT-1:0] act_q;

  // Shadow state worked on during a sweep.
  coord_t         sx_q  [CNT];
  coord_t         sy_q  [CNT];
  vel_t           svx_q [CNT];
  vel_t           svy_q [CNT];
  logic [CNT-1:0] sact_q;

  state_t         state;
  logic [IW-1:0]  idx;
  logic           busy_q, lost_q, overrun_q;
  logic           launch_pend, lost_flag;

  coord_t         step_nx, step_ny;
  vel_t           step_nvx, step_nvy;
  logic           step_fell;

  logic           free_ok;
  logic [IW-1:0]  free_idx;

  ball_step #(
    .SCR_W    (SCR_W),
    .SCR_H    (SCR_H),
    .RADIUS   (RADIUS),
    .PADDLE_Y (PADDLE_Y),
    .PADDLE_HW(PADDLE_HW)
  ) u_step (
    .x        (sx_q[idx]),
    .y        (sy_q[idx]),
    .vx       (svx_q[idx]),
    .vy       (svy_q[idx]),
    .paddle_x (bus.paddle_x),
    .nx       (step_nx),
    .ny       (step_ny),
    .nvx      (step_nvx),
    .nvy      (step_nvy),
    .fell     (step_fell)
  );

  // Lowest-index inactive slot receives a serve; scanning downward lets the lowest win.
  always_comb begin
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = CNT - 1; i >= 0; i--) begin
      if (!act_q[i]) begin
        free_ok  = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // NOTE: the shadow buffer has no reset; it is always reloaded from committed state before use.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.frame_tick) begin
      for (int i = 0; i < CNT; i++) begin
        sx_q[i]  <= xs_q[i];
        sy_q[i]  <= ys_q[i];
        svx_q[i] <= vx_q[i];
        svy_q[i] <= vy_q[i];
      end
      sact_q <= act_q;
    end else if (state == ST_SWEEP && sact_q[idx]) begin
      sx_q[idx] <= step_nx;
      sy_q[idx] <= step_ny;
      if (step_fell) begin
        sact_q[idx] <= 1'b0;
        svx_q[idx]  <= '0;
        svy_q[idx]  <= '0;
      end else begin
        svx_q[idx] <= step_nvx;
        svy_q[idx] <= step_nvy;
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      act_q       <= '0;
      busy_q      <= 1'b0;
      lost_q      <= 1'b0;
      overrun_q   <= 1'b0;
      launch_pend <= 1'b0;
      lost_flag   <= 1'b0;
      for (int i = 0; i < CNT; i++) begin
        xs_q[i] <= '0;
        ys_q[i] <= '0;
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
    end else begin
      lost_q      <= 1'b0;
      overrun_q   <= 1'b0;
      launch_pend <= launch_pend | bus.launch;

      case (state)
        ST_IDLE: begin
          if (bus.frame_tick) begin
            state     <= ST_SWEEP;
            idx       <= '0;
            busy_q    <= 1'b1;
            lost_flag <= 1'b0;
          end else if (launch_pend) begin
            // A request arriving this very cycle stays pending for the next serve.
            launch_pend <= bus.launch;
            if (free_ok) begin
              act_q[free_idx] <= 1'b1;
              xs_q[free_idx]  <= clamp_coord(bus.paddle_x, RADIUS, SCR_W - 1 - RADIUS);
              ys_q[free_idx]  <= SERVE_Y;
              vx_q[free_idx]  <= LAUNCH_VX;
              vy_q[free_idx]  <= LAUNCH_VY;
            end
          end
        end

        ST_SWEEP: begin
          if (bus.frame_tick) overrun_q <= 1'b1;
          if (sact_q[idx] && step_fell) lost_flag <= 1'b1;
          if (idx == IW'(CNT - 1)) begin
            state <= ST_COMMIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        ST_COMMIT: begin
          if (bus.frame_tick) overrun_q <= 1'b1;
          for (int i = 0; i < CNT; i++) begin
            xs_q[i] <= sx_q[i];
            ys_q[i] <= sy_q[i];
            vx_q[i] <= svx_q[i];
            vy_q[i] <= svy_q[i];
          end
          act_q  <= sact_q;
          lost_q <= lost_flag;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < CNT; g++) begin : g_out
    assign bus.xs[g*10 +: 10] = xs_q[g];
    assign bus.ys[g*10 +: 10] = ys_q[g];
  end

  assign bus.active  = act_q;
  assign bus.busy    = busy_q;
  assign bus.lost    = lost_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed self-checking bench for ball_motion_ctrl (CNT=3, 640x480, radius 4, paddle row 440).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ball_motion_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   bc;

  always #5 clk = ~clk;

  ball_motion_ctrl_if #(.CNT(3)) bus ();

  ball_motion_ctrl #(.CNT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] xs_at(input int i);
    return bus.xs[i*10 +: 10];
  endfunction

  function automatic logic [9:0] ys_at(input int i);
    return bus.ys[i*10 +: 10];
  endfunction

  // One serve request; returns on the cycle the served ball is visible.
  task automatic do_launch();
    bus.launch = 1'b1;
    @(negedge clk);
    bus.launch = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One frame; returns on the first cycle busy is low, with the count of busy cycles.
  task automatic run_frame(output int busy_cycles);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 50) begin
      busy_cycles++;
      @(negedge clk);
    end
    if (busy_cycles >= 50) check("frame_timeout", 32'(busy_cycles), 32'd4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.frame_tick = 1'b0;
    bus.launch     = 1'b0;
    bus.paddle_x   = '0;
    rst            = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_xs", bus.xs, 0);
    check("rst_ys", bus.ys, 0);
    check("rst_active", bus.active, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_lost", bus.lost, 0);
    check("rst_overrun", bus.overrun, 0);
    rst = 1'b0;

    // Serve at paddle 320
    bus.paddle_x = 10'd320;
    do_launch();
    check("serve_active", bus.active, 3'b001);
    check("serve_x", xs_at(0), 320);
    check("serve_y", ys_at(0), 435);
    check("serve_busy", bus.busy, 0);

    // One frame: +2,-2, busy for CNT+1 cycles
    run_frame(bc);
    check("frame_busy_cycles", bc, 4);
    check("frame_x", xs_at(0), 322);
    check("frame_y", ys_at(0), 433);
    check("frame_lost", bus.lost, 0);

    // Long run: slot0 served clamped at the right wall, slot1 clamped at the left wall
    pulse_reset();
    check("rst2_active", bus.active, 0);
    bus.paddle_x = 10'd700;
    do_launch();
    check("clamp_right_x", xs_at(0), 635);
    bus.paddle_x = 10'd0;
    do_launch();
    check("clamp_left_x", xs_at(1), 4);
    check("two_active", bus.active, 3'b011);
    bus.paddle_x = 10'd250;

    for (int n = 1; n <= 452; n++) begin
      run_frame(bc);
      if (n == 1) begin
        check("rwall_x0_f1", xs_at(0), 635);
        check("y0_f1", ys_at(0), 433);
        check("x1_f1", xs_at(1), 6);
      end
      if (n == 2) check("rwall_x0_f2", xs_at(0), 633);
      if (n == 215) check("y0_f215", ys_at(0), 5);
      if (n == 216) check("ceil_y0_f216", ys_at(0), 4);
      if (n == 217) check("ceil_y0_f217", ys_at(0), 6);
      if (n == 316) begin
        check("x0_f316", xs_at(0), 5);
        check("rwall_x1_f316", xs_at(1), 635);
      end
      if (n == 317) begin
        check("lwall_x0_f317", xs_at(0), 4);
        check("x1_f317", xs_at(1), 633);
        check("y0_f317", ys_at(0), 206);
      end
      if (n == 318) begin
        check("lwall_x0_f318", xs_at(0), 6);
        check("y0_f318", ys_at(0), 208);
      end
      if (n == 431) check("y0_f431", ys_at(0), 434);
      if (n == 432) begin
        check("paddle_y0_f432", ys_at(0), 436);
        check("paddle_x0_f432", xs_at(0), 234);
        check("miss_y1_f432", ys_at(1), 436);
        check("miss_x1_f432", xs_at(1), 403);
      end
      if (n == 433) begin
        check("bounce_y0_f433", ys_at(0), 434);
        check("pass_y1_f433", ys_at(1), 438);
      end
      if (n == 451) begin
        check("y1_f451", ys_at(1), 474);
        check("active_f451", bus.active, 3'b011);
        check("lost_f451", bus.lost, 0);
      end
      if (n == 452) begin
        check("floor_active_f452", bus.active, 3'b001);
        check("lost_f452", bus.lost, 1);
        check("x0_f452", xs_at(0), 274);
        check("y0_f452", ys_at(0), 396);
      end
    end
    @(negedge clk);
    check("lost_one_cycle", bus.lost, 0);

    // Second tick while busy, and a serve request during the sweep
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    check("overrun_before", bus.overrun, 0);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.launch     = 1'b1;
    check("overrun_pulse", bus.overrun, 1);
    @(negedge clk);
    bus.launch = 1'b0;
    check("overrun_drop", bus.overrun, 0);
    @(negedge clk);
    check("ovr_busy", bus.busy, 0);
    check("ovr_x0", xs_at(0), 276);
    check("ovr_y0", ys_at(0), 394);
    check("ovr_active_pre_serve", bus.active, 3'b001);
    @(negedge clk);
    check("late_serve_active", bus.active, 3'b011);
    check("late_serve_x1", xs_at(1), 250);
    check("late_serve_y1", ys_at(1), 435);
    @(negedge clk);
    check("single_sweep_busy", bus.busy, 0);

    // Reset in the middle of a sweep (idx=1)
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_active", bus.active, 0);
    check("midrst_xs", bus.xs, 0);
    check("midrst_ys", bus.ys, 0);
    check("midrst_busy", bus.busy, 0);

    // Fill all slots, then a request with no free slot is dropped
    bus.paddle_x = 10'd320;
    do_launch();
    bus.paddle_x = 10'd100;
    do_launch();
    bus.paddle_x = 10'd500;
    do_launch();
    check("full_active", bus.active, 3'b111);
    bus.paddle_x = 10'd200;
    do_launch();
    @(negedge clk);
    check("full_drop_active", bus.active, 3'b111);
    check("full_drop_x0", xs_at(0), 320);
    check("full_drop_x1", xs_at(1), 100);
    check("full_drop_x2", xs_at(2), 500);
    run_frame(bc);
    check("full_frame_x0", xs_at(0), 322);
    check("full_frame_x2", xs_at(2), 502);
    check("full_frame_y2", ys_at(2), 433);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
